// File: rtl/serial_operand_feeder_if.sv
// Operand handshake plus serial bit stream between an upstream producer and the feeder.
interface serial_operand_feeder_if #(
    parameter int unsigned W = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         a;
    logic         b;
    logic         bit_valid;
    logic         first;
    logic         last;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, a, b, bit_valid, first, last
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, a, b, bit_valid, first, last
    );
endinterface

// File: rtl/serial_operand_feeder.sv
// Streams a W-bit operand pair LSB-first onto a 1-bit serial adder, marking first/last bits.
// Define SERIAL_OPERAND_FEEDER_BACK_TO_BACK_EN to accept the next pair during the last bit cycle.
module serial_operand_feeder #(
    parameter int unsigned W = 16
) (
    input logic                    clk,
    input logic                    rst,
    serial_operand_feeder_if.slave bus
);
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

`ifdef SERIAL_OPERAND_FEEDER_BACK_TO_BACK_EN
    localparam bit BTB_EN = 1'b1;
`else
    localparam bit BTB_EN = 1'b0;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  sh_a_q, sh_a_d;
    logic [W-1:0]  sh_b_q, sh_b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          a_q, a_d;
    logic          b_q, b_d;
    logic          bit_valid_q, bit_valid_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic          in_ready_q, in_ready_d;
    logic          accept;

    // Next state; outputs are derived from next-state values so they leave flops directly.
    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        cnt_d   = cnt_q;
        accept  = bus.in_valid && in_ready_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_a_d  = bus.in_a;
                    sh_b_d  = bus.in_b;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_q && BTB_EN && accept) begin
                    sh_a_d = bus.in_a;
                    sh_b_d = bus.in_b;
                    cnt_d  = '0;
                end else begin
                    sh_a_d = {1'b0, sh_a_q[W-1:1]};
                    sh_b_d = {1'b0, sh_b_q[W-1:1]};
                    if (last_q) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        bit_valid_d = (state_d == SHIFT);
        first_d     = bit_valid_d && (cnt_d == '0);
        last_d      = bit_valid_d && (cnt_d == CNT_MAX);
        a_d         = bit_valid_d && sh_a_d[0];
        b_d         = bit_valid_d && sh_b_d[0];
        in_ready_d  = !bit_valid_d || (BTB_EN && last_d);
    end

    // Reset aborts any word in flight; the feeder comes back ready to accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            cnt_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            bit_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            bit_valid_q <= bit_valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.first     = first_q;
    assign bus.last      = last_q;
endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder: four width lanes (2, 4, 5, 16) sharing clock and reset.
module tb_serial_operand_feeder;
`ifdef SERIAL_OPERAND_FEEDER_BACK_TO_BACK_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif
    localparam int LW [4] = '{2, 4, 5, 16};

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic [7:0]  len;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic        lane_valid [4];
    logic [15:0] lane_in_a  [4];
    logic [15:0] lane_in_b  [4];
    logic        lane_rdy   [4];
    logic        lane_bv    [4];
    logic        lane_a     [4];
    logic        lane_b     [4];
    logic        lane_first [4];
    logic        lane_last  [4];

    rec_t got_q [4][$];

    serial_operand_feeder_if #(.W(2))  if2  ();
    serial_operand_feeder_if #(.W(4))  if4  ();
    serial_operand_feeder_if #(.W(5))  if5  ();
    serial_operand_feeder_if #(.W(16)) if16 ();

    serial_operand_feeder #(.W(2))  u_dut2  (.clk(clk), .rst(rst), .bus(if2));
    serial_operand_feeder #(.W(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
    serial_operand_feeder #(.W(5))  u_dut5  (.clk(clk), .rst(rst), .bus(if5));
    serial_operand_feeder #(.W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

    assign if2.in_valid  = lane_valid[0];
    assign if2.in_a      = lane_in_a[0][1:0];
    assign if2.in_b      = lane_in_b[0][1:0];
    assign if4.in_valid  = lane_valid[1];
    assign if4.in_a      = lane_in_a[1][3:0];
    assign if4.in_b      = lane_in_b[1][3:0];
    assign if5.in_valid  = lane_valid[2];
    assign if5.in_a      = lane_in_a[2][4:0];
    assign if5.in_b      = lane_in_b[2][4:0];
    assign if16.in_valid = lane_valid[3];
    assign if16.in_a     = lane_in_a[3];
    assign if16.in_b     = lane_in_b[3];

    assign lane_rdy[0] = if2.in_ready;   assign lane_bv[0] = if2.bit_valid;
    assign lane_a[0]   = if2.a;          assign lane_b[0]  = if2.b;
    assign lane_first[0] = if2.first;    assign lane_last[0] = if2.last;
    assign lane_rdy[1] = if4.in_ready;   assign lane_bv[1] = if4.bit_valid;
    assign lane_a[1]   = if4.a;          assign lane_b[1]  = if4.b;
    assign lane_first[1] = if4.first;    assign lane_last[1] = if4.last;
    assign lane_rdy[2] = if5.in_ready;   assign lane_bv[2] = if5.bit_valid;
    assign lane_a[2]   = if5.a;          assign lane_b[2]  = if5.b;
    assign lane_first[2] = if5.first;    assign lane_last[2] = if5.last;
    assign lane_rdy[3] = if16.in_ready;  assign lane_bv[3] = if16.bit_valid;
    assign lane_a[3]   = if16.a;         assign lane_b[3]  = if16.b;
    assign lane_first[3] = if16.first;   assign lane_last[3] = if16.last;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream model: serial adder plus deserializer, one word record per last bit.
    initial begin
        int   pos   [4];
        logic carry [4];
        rec_t cur   [4];
        for (int l = 0; l < 4; l++) begin
            pos[l] = 0; carry[l] = 1'b0; cur[l] = '0;
        end
        forever begin
            @(negedge clk);
            for (int l = 0; l < 4; l++) begin
                if (rst && lane_bv[l]) begin
                    logic c;
                    if (lane_first[l]) begin
                        pos[l] = 0; carry[l] = 1'b0; cur[l] = '0;
                    end
                    c = carry[l];
                    if (pos[l] < 16) begin
                        cur[l].a[pos[l]] = lane_a[l];
                        cur[l].b[pos[l]] = lane_b[l];
                        cur[l].s[pos[l]] = lane_a[l] ^ lane_b[l] ^ c;
                    end
                    carry[l] = (lane_a[l] & lane_b[l]) | (lane_a[l] & c) | (lane_b[l] & c);
                    pos[l]++;
                    if (lane_last[l]) begin
                        cur[l].len = 8'(pos[l]);
                        got_q[l].push_back(cur[l]);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input int l, input logic [15:0] va, input logic [15:0] vb);
        int n;
        @(negedge clk);
        lane_valid[l] = 1'b1;
        lane_in_a[l]  = va;
        lane_in_b[l]  = vb;
        n = 0;
        while (lane_rdy[l] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL send_timeout lane %0d: in_ready=%b, required 1", l, lane_rdy[l]);
            lane_valid[l] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic rec_t model(input int w, input logic [15:0] va, input logic [15:0] vb);
        int unsigned m = (32'd1 << w) - 1;
        rec_t r;
        r.a   = 16'(va & m);
        r.b   = 16'(vb & m);
        r.s   = 16'((int'(va & m) + int'(vb & m)) & m);
        r.len = 8'(w);
        return r;
    endfunction

    task automatic check_rec(input string name, input int l, input rec_t exp);
        rec_t r;
        checks++;
        if (got_q[l].size() == 0) begin
            errors++;
            $display("FAIL %s: no word collected, required a=%h b=%h", name, exp.a, exp.b);
        end else begin
            r = got_q[l].pop_front();
            if (r !== exp) begin
                errors++;
                $display("FAIL %s: got a=%h b=%h sum=%h len=%0d, required a=%h b=%h sum=%h len=%0d",
                         name, r.a, r.b, r.s, r.len, exp.a, exp.b, exp.s, exp.len);
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 4; l++) begin
            checks++;
            if ({lane_bv[l], lane_a[l], lane_b[l], lane_first[l], lane_last[l]} !== 5'b0) begin
                errors++;
                $display("FAIL reset_hold lane %0d: outputs %b, required 00000", l,
                         {lane_bv[l], lane_a[l], lane_b[l], lane_first[l], lane_last[l]});
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int l = 0; l < 4; l++) begin
            checks++;
            if ({lane_bv[l], lane_a[l], lane_b[l], lane_first[l], lane_last[l], lane_rdy[l]} !== 6'b000001) begin
                errors++;
                $display("FAIL reset_release lane %0d: {bv,a,b,first,last,rdy}=%b, required 000001", l,
                         {lane_bv[l], lane_a[l], lane_b[l], lane_first[l], lane_last[l], lane_rdy[l]});
            end
        end
    endtask

    task automatic test_single_word();
        logic [15:0] va = 16'b1001;
        logic [15:0] vb = 16'b0011;
        got_q[1].delete();
        send(1, va, vb);
        lane_valid[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [4:0] exp;
            @(negedge clk);
            exp = {1'b1, va[i], vb[i], i == 0, i == 3};
            checks++;
            if ({lane_bv[1], lane_a[1], lane_b[1], lane_first[1], lane_last[1]} !== exp) begin
                errors++;
                $display("FAIL single_bit%0d: {bv,a,b,first,last}=%b, required %b", i,
                         {lane_bv[1], lane_a[1], lane_b[1], lane_first[1], lane_last[1]}, exp);
            end
        end
        @(negedge clk);
        checks++;
        if ({lane_bv[1], lane_rdy[1]} !== 2'b01) begin
            errors++;
            $display("FAIL single_after: {bv,rdy}=%b, required 01", {lane_bv[1], lane_rdy[1]});
        end
        check_rec("single_sum", 1, model(4, va, vb));
    endtask

    task automatic test_ignore_busy();
        int t0;
        int t1;
        got_q[1].delete();
        send(1, 16'h6, 16'h9);
        t0 = cyc;
        send(1, 16'hF, 16'hF);
        t1 = cyc;
        lane_valid[1] = 1'b0;
        checks++;
        if (t1 - t0 != (BTB ? 4 : 5)) begin
            errors++;
            $display("FAIL busy_accept_gap: %0d cycles between handshakes, required %0d",
                     t1 - t0, BTB ? 4 : 5);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (got_q[1].size() != 2) begin
            errors++;
            $display("FAIL busy_word_count: %0d words, required 2", got_q[1].size());
        end
        check_rec("busy_word0", 1, model(4, 16'h6, 16'h9));
        check_rec("busy_word1", 1, model(4, 16'hF, 16'hF));
    endtask

    task automatic test_back_to_back();
        logic [2:0] tr [10];
        int s1 = BTB ? 4 : 5;
        got_q[1].delete();
        fork
            begin
                send(1, 16'h5, 16'hA);
                send(1, 16'hF, 16'h1);
                lane_valid[1] = 1'b0;
            end
            begin
                @(negedge clk);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    tr[i] = {lane_bv[1], lane_first[1], lane_last[1]};
                end
            end
        join
        for (int i = 0; i < 10; i++) begin
            logic [2:0] exp;
            exp[2] = (i < 4) || (i >= s1 && i < s1 + 4);
            exp[1] = (i == 0) || (i == s1);
            exp[0] = (i == 3) || (i == s1 + 3);
            checks++;
            if (tr[i] !== exp) begin
                errors++;
                $display("FAIL b2b_cycle%0d: {bv,first,last}=%b, required %b", i, tr[i], exp);
            end
        end
        check_rec("b2b_word0", 1, model(4, 16'h5, 16'hA));
        check_rec("b2b_word1", 1, model(4, 16'hF, 16'h1));
    endtask

    task automatic test_reset_mid_word();
        logic [15:0] va = 16'hABCD;
        logic [15:0] vb = 16'h1234;
        for (int l = 0; l < 4; l++) got_q[l].delete();
        send(3, va, vb);
        lane_valid[3] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({lane_bv[3], lane_a[3], lane_b[3], lane_first[3], lane_last[3]} !== {1'b1, va[2], vb[2], 2'b00}) begin
            errors++;
            $display("FAIL midrst_bit2: {bv,a,b,first,last}=%b, required %b",
                     {lane_bv[3], lane_a[3], lane_b[3], lane_first[3], lane_last[3]},
                     {1'b1, va[2], vb[2], 2'b00});
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({lane_bv[3], lane_a[3], lane_b[3], lane_first[3], lane_last[3]} !== 5'b0) begin
            errors++;
            $display("FAIL midrst_abort: {bv,a,b,first,last}=%b, required 00000",
                     {lane_bv[3], lane_a[3], lane_b[3], lane_first[3], lane_last[3]});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checks++;
        if (got_q[3].size() != 0) begin
            errors++;
            $display("FAIL midrst_discard: %0d partial words collected, required 0", got_q[3].size());
        end
        send(3, 16'h8001, 16'h0001);
        lane_valid[3] = 1'b0;
        @(negedge clk);
        checks++;
        if ({lane_bv[3], lane_a[3], lane_b[3], lane_first[3], lane_last[3]} !== 5'b11110) begin
            errors++;
            $display("FAIL midrst_new_bit0: {bv,a,b,first,last}=%b, required 11110",
                     {lane_bv[3], lane_a[3], lane_b[3], lane_first[3], lane_last[3]});
        end
        repeat (15) @(negedge clk);
        checks++;
        if ({lane_bv[3], lane_a[3], lane_b[3], lane_first[3], lane_last[3]} !== 5'b11001) begin
            errors++;
            $display("FAIL midrst_new_bit15: {bv,a,b,first,last}=%b, required 11001",
                     {lane_bv[3], lane_a[3], lane_b[3], lane_first[3], lane_last[3]});
        end
        @(negedge clk);
        check_rec("midrst_new_word", 3, model(16, 16'h8001, 16'h0001));
    endtask

    task automatic test_sweep(input int l);
        rec_t exp_q[$];
        int   w = LW[l];
        got_q[l].delete();
        for (int n = 0; n < 200; n++) begin
            logic [15:0] va = 16'($urandom);
            logic [15:0] vb = 16'($urandom);
            exp_q.push_back(model(w, va, vb));
            send(l, va, vb);
            if ($urandom_range(0, 3) == 0) begin
                lane_valid[l] = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        lane_valid[l] = 1'b0;
        repeat (w + 4) @(negedge clk);
        checks++;
        if (got_q[l].size() != 200) begin
            errors++;
            $display("FAIL sweep_w%0d_count: %0d words, required 200", w, got_q[l].size());
        end
        while (exp_q.size() > 0) begin
            rec_t e = exp_q.pop_front();
            check_rec($sformatf("sweep_w%0d_word", w), l, e);
        end
    endtask

    initial begin
        for (int l = 0; l < 4; l++) begin
            lane_valid[l] = 1'b0;
            lane_in_a[l]  = '0;
            lane_in_b[l]  = '0;
        end
        test_reset();
        test_single_word();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_word();
        test_sweep(0);
        test_sweep(2);
        test_sweep(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
